dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the data-memory interface that the MEM stage drives.
- Accepts one load or store per valid/ready request handshake.
- Models a configurable number of wait states, then returns read data or an error over a valid/ready response handshake.
- Replaces the zero-latency combinational data memory, so the pipeline can be tested against slow memory.

Parameters:
- DEPTH, 32, number of 32-bit words in the array (power of two, ≥2)
- LATENCY, 2, wait-state cycles between request acceptance and response (≥1)
- AW, $clog2(DEPTH), word-index width (derived, not overridden)

Ports:
- clk  input  1  single clock, all state updates on its rising edge
- rst  input  1  reset, synchronous and active-high
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1=store, 0=load
- req_addr  input  32  byte address
- req_wdata  input  32  store data
- rsp_valid  output  1  response present
- rsp_ready  input  1  requester accepts the response
- rsp_rdata  output  32  load data (0 for stores and errors)
- rsp_err  output  1  misaligned or out-of-range access
- busy  output  1  state != IDLE

Behaviour:
- FSM has three states: IDLE, WAIT, RESP. req_ready = (state==IDLE); rsp_valid = (state==RESP).
- IDLE: on req_valid&&req_ready, latch we/addr/wdata, set cnt=LATENCY-1, go to WAIT. Otherwise stay in IDLE.
- WAIT: if cnt!=0, decrement cnt. If cnt==0, perform the access on this edge and go to RESP.
  - Store: array[idx] <= wdata.
  - Load: rsp_rdata <= array[idx].
- idx = addr[AW+1:2].
- Error when addr[1:0]!=0 or addr[31:AW+2]!=0:
  - rsp_err=1 and rsp_rdata=0.
  - No array write occurs.
- RESP: hold rsp_rdata and rsp_err stable until rsp_ready. On rsp_valid&&rsp_ready, go to IDLE and clear rsp_rdata and rsp_err to 0.
- Timing:
  - Request accepted in cycle c → WAIT in cycles c+1..c+LATENCY → rsp_valid first high in cycle c+LATENCY+1.
  - Back-to-back throughput is one transaction per LATENCY+2 cycles; there is no accept during RESP.
- Store response: rsp_valid with rsp_rdata=0. The store is visible to any load accepted after the store's response handshake.
- Requests arriving while busy are not accepted. The requester must hold req_* stable until req_ready.
- Reset (rst=1 at an edge):
  - Output/state values: state=IDLE, cnt=0, rsp_rdata=0, rsp_err=0, req_ready=1 from the next cycle, busy=0.
  - Array contents are unchanged.
  - A transaction in WAIT with cnt!=0 is abandoned; its store is not committed.
- Reset has priority over every transition, including the commit edge.
- rsp_ready while not in RESP is ignored.

Optional Feature:
- Macro: DMEM_BYTE_EN_EN.
- Defined:
  - Adds port req_be, input, 4 bits, latched with the request.
  - A store writes only the bytes whose be bit is 1; be=4'b0000 writes nothing but still responds normally.
  - Loads ignore be.
- Undefined:
  - No req_be port.
  - Every store writes the full word.

Decomposition:
- Package dmem_pkg holds:
  - state enum (IDLE=2'd0, WAIT=2'd1, RESP=2'd2)
  - WORD_W=32
  - function for misalignment/range check
- Sub-module dmem_array holds the storage:
  - parameters DEPTH and AW
  - ports clk, we, be (all-ones when the feature is off), idx, wdata, rdata
  - synchronous write, combinational read sampled by the FSM at commit

Test Plan:
- LATENCY=2. Store addr 0x0000_0010, data 0xDEAD_BEEF; then load 0x10. Required:
  - Each rsp_valid arrives exactly 3 cycles after acceptance.
  - Load returns rdata=0xDEAD_BEEF with err=0.
- Load addr 0x0000_0012 (misaligned) → rsp_err=1, rdata=0. A prior load of 0x10 is unchanged.
- DEPTH=32. Store addr 0x0000_0080 (index 32, out of range) → err=1. Load 0x0 afterwards returns its previous value.
- Hold rsp_ready=0 for 5 cycles in RESP. Required:
  - rsp_valid and rdata stay stable.
  - req_ready stays 0.
  - After the handshake, req_ready=1 next cycle.
- Assert rst during WAIT of a store (cnt=1) to 0x20 with 0x1234_5678 → IDLE next cycle, no response; a later load 0x20 returns the old value.
- DMEM_BYTE_EN_EN defined. Store 0xFFFF_FFFF to 0x4, then store 0x1122_3344 with be=4'b0101 → load 0x4 returns 0xFF22_FF44.

Source files
------------

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder:
//   - dmemState_t  : responder FSM states (IDLE, WAIT, RESP)
//   - WORD_W       : data word width in bits
//   - BE_W         : number of byte lanes per word
//   - isBadAddr()  : flags a byte address that is misaligned or beyond the array
// Optional feature macro used by the users of this package: DMEM_BYTE_EN_EN.
// -----------------------------------------------------------------------------
package dmem_pkg;

   localparam int WORD_W = 32;
   localparam int BE_W   = WORD_W / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmemState_t;

   // An access is rejected when it is not word aligned, or when any address
   // bit above the word-index field is set (the word lies past the array).
   function automatic logic isBadAddr(input logic [WORD_W-1:0] addr,
                                      input int                aw);
      logic [WORD_W-1:0] upper;
      upper = addr >> (aw + 2);
      return (addr[1:0] != 2'b00) || (upper != '0);
   endfunction

endpackage : dmem_pkg

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Word storage for the data-memory responder. Byte-lane synchronous write,
// combinational read of the addressed word. Contents are never reset.
//
// Parameters:
//   DEPTH  number of WORD_W-bit words (power of two)
//   AW     word-index width, $clog2(DEPTH)
// Ports:
//   clk    clock, writes happen on its rising edge
//   we     write enable for this edge
//   be     per-byte write enables (all ones when byte enables are disabled)
//   idx    word index for both the write and the read
//   wdata  write data
//   rdata  current contents of word idx
// -----------------------------------------------------------------------------
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [BE_W-1:0]   be,
   input  logic [AW-1:0]     idx,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < BE_W; b++) begin
            if (be[b]) begin
               mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   assign rdata = mem[idx];

endmodule : dmem_array

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Memory-side responder for the MEM-stage data interface. Accepts one load or
// store per request handshake, waits LATENCY cycles, performs the access, then
// presents read data / error on the response channel until it is taken.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid and ready are both 1. The request side must hold req_* stable
// while req_valid is 1 and req_ready is 0. The responder holds rsp_rdata and
// rsp_err stable while rsp_valid is 1 and rsp_ready is 0.
//
// Parameters:
//   DEPTH    words in the array (power of two, >= 2)
//   LATENCY  wait-state cycles between acceptance and commit (>= 1)
//   AW       word-index width, derived from DEPTH
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_we                1 = store, 0 = load
//   req_addr              byte address
//   req_wdata             store data
//   req_be                byte enables (only when DMEM_BYTE_EN_EN is defined)
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             load data, 0 for stores and errors
//   rsp_err               misaligned or out-of-range access
//   busy                  FSM is not in IDLE (also serves as state visibility)
//
// Optional feature: define DMEM_BYTE_EN_EN to add req_be; otherwise every
// store writes the whole word.
// -----------------------------------------------------------------------------
module dmem_responder
   import dmem_pkg::*;
#(
   parameter  int DEPTH   = 32,
   parameter  int LATENCY = 2,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [WORD_W-1:0] req_addr,
   input  logic [WORD_W-1:0] req_wdata,
`ifdef DMEM_BYTE_EN_EN
   input  logic [BE_W-1:0]   req_be,
`endif
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [WORD_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              busy
);

   // Counter just wide enough to hold LATENCY-1.
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   dmemState_t        state;
   dmemState_t        stateNext;
   logic [CW-1:0]     cnt;

   // Request captured at acceptance.
   logic              weQ;
   logic [WORD_W-1:0] addrQ;
   logic [WORD_W-1:0] wdataQ;
   logic [BE_W-1:0]   beQ;
   logic [BE_W-1:0]   reqBe;

   logic [WORD_W-1:0] rdataQ;
   logic              errQ;

   logic              accept;
   logic              commit;
   logic              addrErr;
   logic              arrWe;
   logic [AW-1:0]     idx;
   logic [WORD_W-1:0] arrRdata;

`ifdef DMEM_BYTE_EN_EN
   assign reqBe = req_be;
`else
   assign reqBe = '1;
`endif

   assign accept  = req_valid && (state == IDLE);
   assign commit  = (state == WAIT) && (cnt == '0);
   assign addrErr = isBadAddr(addrQ, AW);
   assign idx     = addrQ[AW+1:2];

   // Reset wins over the commit edge, so the write is masked by rst as well.
   assign arrWe   = commit && weQ && !addrErr && !rst;

   dmem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) uArray (
      .clk   (clk),
      .we    (arrWe),
      .be    (beQ),
      .idx   (idx),
      .wdata (wdataQ),
      .rdata (arrRdata)
   );

   // Next-state and handshake outputs.
   always_comb begin
      stateNext = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      busy      = 1'b1;
      unique case (state)
         IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) begin
               stateNext = WAIT;
            end
         end
         WAIT: begin
            if (cnt == '0) begin
               stateNext = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               stateNext = IDLE;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Wait-state counter and captured request.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         weQ    <= 1'b0;
         addrQ  <= '0;
         wdataQ <= '0;
         beQ    <= '1;
      end else if (accept) begin
         cnt    <= CW'(LATENCY - 1);
         weQ    <= req_we;
         addrQ  <= req_addr;
         wdataQ <= req_wdata;
         beQ    <= reqBe;
      end else if ((state == WAIT) && (cnt != '0)) begin
         cnt    <= cnt - CW'(1);
      end
   end

   // Response registers: loaded at commit, held through RESP, cleared on the
   // response handshake so they read 0 whenever no response is pending.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdataQ <= '0;
         errQ   <= 1'b0;
      end else if (commit) begin
         errQ   <= addrErr;
         rdataQ <= (!weQ && !addrErr) ? arrRdata : '0;
      end else if ((state == RESP) && rsp_ready) begin
         rdataQ <= '0;
         errQ   <= 1'b0;
      end
   end

   assign rsp_rdata = rdataQ;
   assign rsp_err   = errQ;

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Randomised and directed traffic against dmem_responder. The driver pushes
// the expected response of every accepted request (from a word-array model)
// into exp_q; an independent monitor pops and compares on each response
// handshake and also checks latency, stall stability and post-handshake
// clearing. Define DMEM_BYTE_EN_EN to exercise byte enables.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

   localparam int DEPTH   = 32;
   localparam int LATENCY = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
`ifdef DMEM_BYTE_EN_EN
   logic [3:0]  req_be = 4'hF;
`endif
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;

   dmem_responder #(
      .DEPTH   (DEPTH),
      .LATENCY (LATENCY)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
`ifdef DMEM_BYTE_EN_EN
      .req_be    (req_be),
`endif
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .busy      (busy)
   );

   // ---------------------------------------------------------------- clock
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ------------------------------------------------------------ scoreboard
   logic [32:0] exp_q[$];      // {err, rdata}
   int          acc_q[$];      // cycle of each tracked acceptance
   logic [31:0] model[DEPTH];
   int          vectors     = 0;
   int          miscompares = 0;
   int          stall_n     = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // --------------------------------------------------------------- driver
   // Called at a negedge. Returns at the negedge following acceptance.
   task automatic issue(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input bit track);
      int          waited;
      logic        err;
      logic [3:0]  beEff;
      logic [32:0] e;
      int          wi;
      waited    = 0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
`ifdef DMEM_BYTE_EN_EN
      req_be    = be;
      beEff     = be;
`else
      beEff     = 4'hF;
`endif
      while (!req_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) begin
         vectors++;
         miscompares++;
         $display("FAIL accept_timeout: req_ready=%0b, expected 1", req_ready);
         req_valid = 1'b0;
         return;
      end
      if (track) begin
         acc_q.push_back(cyc);
         err = (addr % 4 != 0) || (addr >= DEPTH * 4);
         wi  = int'(addr / 4);
         if (err) begin
            e = {1'b1, 32'h0};
         end else if (we) begin
            for (int b = 0; b < 4; b++)
               if (beEff[b]) model[wi][8*b +: 8] = wdata[8*b +: 8];
            e = {1'b0, 32'h0};
         end else begin
            e = {1'b0, model[wi]};
         end
         exp_q.push_back(e);
      end
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) begin
         vectors++;
         miscompares++;
         $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
      end
   endtask

   function automatic logic [31:0] randAddr();
      logic [31:0] a;
      case ($urandom_range(0, 9))
         0: a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
         1: begin
            a = $urandom;
            if (a < DEPTH * 4) a = a + DEPTH * 4;
         end
         default: a = 32'($urandom_range(0, DEPTH - 1) * 4);
      endcase
      return a;
   endfunction

   // -------------------------------------------------------------- monitor
   initial begin : monitor
      logic        prevValid;
      logic        prevHeld;
      logic        postHs;
      logic [31:0] heldRdata;
      logic        heldErr;
      logic [32:0] e;
      int          acc;
      prevValid = 1'b0;
      prevHeld  = 1'b0;
      postHs    = 1'b0;
      heldRdata = '0;
      heldErr   = 1'b0;
      forever begin
         @(negedge clk);
         if (postHs) begin
            check("req_ready_after_handshake", req_ready, 1);
            check("rsp_valid_after_handshake", rsp_valid, 0);
            check("rsp_rdata_cleared", rsp_rdata, 0);
            check("rsp_err_cleared", rsp_err, 0);
            postHs = 1'b0;
         end
         if (prevHeld) begin
            check("stall_rsp_valid", rsp_valid, 1);
            check("stall_rsp_rdata", rsp_rdata, heldRdata);
            check("stall_rsp_err", rsp_err, heldErr);
            check("stall_req_ready", req_ready, 0);
         end
         if (rsp_valid && !prevValid) begin
            if (acc_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_response: rsp_valid=1 with no request outstanding");
            end else begin
               acc = acc_q.pop_front();
               check("rsp_latency", 32'(cyc - acc), 32'(LATENCY + 1));
            end
         end
         if (rsp_valid && stall_n > 0) begin
            rsp_ready = 1'b0;
            stall_n--;
         end else begin
            rsp_ready = ($urandom_range(0, 3) != 0);
         end
         prevHeld  = rsp_valid && !rsp_ready;
         heldRdata = rsp_rdata;
         heldErr   = rsp_err;
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_handshake: rdata=%h err=%0b with empty queue",
                        rsp_rdata, rsp_err);
            end else begin
               e = exp_q.pop_front();
               check("rsp_rdata", rsp_rdata, e[31:0]);
               check("rsp_err", rsp_err, e[32]);
            end
            postHs = 1'b1;
         end
         prevValid = rsp_valid;
      end
   end

   // ------------------------------------------------------------- watchdog
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      miscompares++;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // ------------------------------------------------------------- stimulus
   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_req_ready", req_ready, 1);
      check("reset_busy", busy, 0);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_rsp_rdata", rsp_rdata, 0);
      check("reset_rsp_err", rsp_err, 0);
      rst = 1'b0;
      @(negedge clk);

      // Give every word a known value.
      for (int i = 0; i < DEPTH; i++)
         issue(1'b1, 32'(i * 4), $urandom, 4'hF, 1'b1);

      // Directed: store/load, misaligned, out of range.
      issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1);
      issue(1'b0, 32'h10, 32'h0, 4'hF, 1'b1);
      issue(1'b0, 32'h12, 32'h0, 4'hF, 1'b1);
      issue(1'b0, 32'h10, 32'h0, 4'hF, 1'b1);
      issue(1'b1, 32'h80, 32'hCAFE_F00D, 4'hF, 1'b1);
      issue(1'b0, 32'h0, 32'h0, 4'hF, 1'b1);
      drain();

      // Five-cycle response stall on a load.
      stall_n = 5;
      issue(1'b0, 32'h10, 32'h0, 4'hF, 1'b1);
      drain();

      // Reset while a store waits with cnt=1: no commit, no response.
      issue(1'b1, 32'h20, 32'h1234_5678, 4'hF, 1'b0);
      check("busy_in_wait", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_req_ready", req_ready, 1);
      check("abort_rsp_valid", rsp_valid, 0);
      repeat (4) begin
         @(negedge clk);
         check("abort_no_response", rsp_valid, 0);
      end
      issue(1'b0, 32'h20, 32'h0, 4'hF, 1'b1);
      drain();

`ifdef DMEM_BYTE_EN_EN
      issue(1'b1, 32'h4, 32'hFFFF_FFFF, 4'hF, 1'b1);
      issue(1'b1, 32'h4, 32'h1122_3344, 4'b0101, 1'b1);
      issue(1'b0, 32'h4, 32'h0, 4'hF, 1'b1);
      drain();
      check("byte_enable_model", model[1], 32'hFF22_FF44);
      issue(1'b1, 32'h8, 32'hAAAA_AAAA, 4'b0000, 1'b1);
      issue(1'b0, 32'h8, 32'h0, 4'hF, 1'b1);
      drain();
`endif

      // Random traffic.
      for (int i = 0; i < 300; i++)
         issue(1'($urandom_range(0, 1)), randAddr(), $urandom,
               4'($urandom_range(0, 15)), 1'b1);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_dmem_responder
